// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM image constants and loader/UART state encodings
package sram_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam logic [3:0] END_OPCODE = 4'b0000;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    LD_LO,
    LD_HI,
    LD_SETUP,
    LD_PULSE,
    LD_HOLD,
    LD_DONE
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // The player decodes the same opcode field, so keep the test in one place.
  function automatic logic is_end_word(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: 4] == END_OPCODE;
  endfunction

endpackage

// File: rtl/sram_loader_uart_rx.sv
// rtl/sram_loader_uart_rx.sv - 8N1 UART receiver with centre sampling and stop-bit check
module uart_rx
  import sram_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) valid_d = 1'b1;
          else         ferr_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte      = shift_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/sram_loader.sv
// rtl/sram_loader.sv - UART-fed program image writer for the external SRAM
module sram_loader
  import sram_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int WE_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              UART_RX,
  output logic              SRAM_WE,
  output logic              SRAM_CE,
  output logic              SRAM_OE,
  output logic              SRAM_LB,
  output logic              SRAM_UB,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [DATA_W-1:0] SRAM_DQ_O,
  output logic              SRAM_DQ_OE,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR,
  output logic [ADDR_W-1:0] WORD_COUNT
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int PW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(WE_CYCLES - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk         (CLK),
    .rst_n       (RST_N),
    .rx          (UART_RX),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  ld_state_e          state_q, state_d;
  logic               hold_full_q, hold_full_d;
  logic [7:0]         hold_byte_q, hold_byte_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  logic [PW-1:0]      pulse_q, pulse_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               consume;
  logic               writing;

  logic               we_q, we_d;
  logic               en_q, en_d;
  logic               dq_oe_q, dq_oe_d;
  logic [ADDR_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  dq_q, dq_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= LD_LO;
      hold_full_q <= 1'b0;
      hold_byte_q <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      pulse_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b1;
      en_q        <= 1'b1;
      dq_oe_q     <= 1'b0;
      a_q         <= '0;
      dq_q        <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_byte_q <= hold_byte_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      pulse_q     <= pulse_d;
      err_q       <= err_d;
      done_q      <= done_d;
      we_q        <= we_d;
      en_q        <= en_d;
      dq_oe_q     <= dq_oe_d;
      a_q         <= a_d;
      dq_q        <= dq_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_byte_d = hold_byte_q;
    word_d      = word_q;
    addr_d      = addr_q;
    count_d     = count_q;
    pulse_d     = pulse_q;
    err_d       = err_q;
    consume     = 1'b0;

    case (state_q)
      LD_LO: begin
        if (hold_full_q) begin
          word_d[7:0] = hold_byte_q;
          consume     = 1'b1;
          state_d     = LD_HI;
        end
      end
      LD_HI: begin
        if (hold_full_q) begin
          word_d[15:8] = hold_byte_q;
          consume      = 1'b1;
          state_d      = LD_SETUP;
        end
      end
      LD_SETUP: begin
        pulse_d = '0;
        state_d = LD_PULSE;
      end
      LD_PULSE: begin
        if (pulse_q == PULSE_LAST) state_d = LD_HOLD;
        else                       pulse_d = pulse_q + 1'b1;
      end
      LD_HOLD: begin
        count_d = count_q + 1'b1;
        if (is_end_word(word_q)) begin
          state_d = LD_DONE;
        end else if (addr_q == ADDR_MAX) begin
          err_d   = 1'b1;
          state_d = LD_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = LD_LO;
        end
      end
      LD_DONE: ;
      default: state_d = LD_LO;
    endcase

    if (consume) hold_full_d = 1'b0;

    // Once the image is loaded the line is ignored entirely, errors included.
    if (state_q != LD_DONE) begin
      if (rx_frame_err) err_d = 1'b1;
      if (rx_valid) begin
        if (hold_full_q && !consume) begin
          err_d = 1'b1;
        end else begin
          hold_full_d = 1'b1;
          hold_byte_d = rx_byte;
        end
      end
    end

    done_d  = (state_d == LD_DONE);
    writing = (state_d == LD_SETUP) || (state_d == LD_PULSE) || (state_d == LD_HOLD);
    we_d    = (state_d != LD_PULSE);
    en_d    = !writing;
    dq_oe_d = writing;
    a_d     = writing ? addr_d : '0;
    dq_d    = writing ? word_d : '0;
  end

  assign SRAM_WE    = we_q;
  assign SRAM_CE    = en_q;
  assign SRAM_OE    = 1'b1;
  assign SRAM_LB    = en_q;
  assign SRAM_UB    = en_q;
  assign SRAM_A     = a_q;
  assign SRAM_DQ_O  = dq_q;
  assign SRAM_DQ_OE = dq_oe_q;
  assign LOAD_DONE  = done_q;
  assign LOAD_ERR   = err_q;
  assign WORD_COUNT = count_q;

endmodule

// File: tb/tb_sram_loader.sv
// tb/tb_sram_loader.sv - self-checking bench for sram_loader: vector table, corner sequences, random image
module tb_sram_loader;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rx1, rx2;

  logic        we1, ce1, oe1, lb1, ub1, dqoe1, done1, err1;
  logic [17:0] a1, cnt1;
  logic [15:0] dq1;
  logic        we2, ce2, oe2, lb2, ub2, dqoe2, done2, err2;
  logic [17:0] a2, cnt2;
  logic [15:0] dq2;

  sram_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WE_CYCLES(3)) dut (
    .CLK(clk), .RST_N(rst_n), .UART_RX(rx1),
    .SRAM_WE(we1), .SRAM_CE(ce1), .SRAM_OE(oe1), .SRAM_LB(lb1), .SRAM_UB(ub1),
    .SRAM_A(a1), .SRAM_DQ_O(dq1), .SRAM_DQ_OE(dqoe1),
    .LOAD_DONE(done1), .LOAD_ERR(err1), .WORD_COUNT(cnt1)
  );

  sram_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WE_CYCLES(1000)) dut_slow (
    .CLK(clk), .RST_N(rst_n), .UART_RX(rx2),
    .SRAM_WE(we2), .SRAM_CE(ce2), .SRAM_OE(oe2), .SRAM_LB(lb2), .SRAM_UB(ub2),
    .SRAM_A(a2), .SRAM_DQ_O(dq2), .SRAM_DQ_OE(dqoe2),
    .LOAD_DONE(done2), .LOAD_ERR(err2), .WORD_COUNT(cnt2)
  );

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
    int          len;
  } wr_t;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [17:0] addr;
    logic [15:0] data;
    logic [17:0] cnt;
    logic        done;
  } vec_t;

  wr_t wr_q[$];
  wr_t wr2_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus watcher: records every write pulse and counts protocol violations.
  int          we_len = 0, we2_len = 0, oe_bad = 0, idle_bad = 0, stable_bad = 0;
  logic [17:0] cap_a, cap2_a;
  logic [15:0] cap_d, cap2_d;
  logic        prev_ce;
  wr_t         w1, w2;

  always @(negedge clk) begin
    if (oe1 !== 1'b1 || oe2 !== 1'b1) oe_bad++;
    if (!rst_n) begin
      we_len  = 0;
      we2_len = 0;
      prev_ce = 1'b1;
    end else begin
      if (ce1 === 1'b1 && (we1 !== 1'b1 || lb1 !== 1'b1 || ub1 !== 1'b1 ||
                           a1 !== '0 || dq1 !== '0 || dqoe1 !== 1'b0)) idle_bad++;
      if (we1 === 1'b0) begin
        if (we_len == 0) begin
          cap_a = a1;
          cap_d = dq1;
          if (prev_ce !== 1'b0) stable_bad++;
        end else if (a1 !== cap_a || dq1 !== cap_d) begin
          stable_bad++;
        end
        if (ce1 !== 1'b0 || lb1 !== 1'b0 || ub1 !== 1'b0 || dqoe1 !== 1'b1) stable_bad++;
        we_len++;
      end else if (we_len != 0) begin
        if (ce1 !== 1'b0 || a1 !== cap_a || dq1 !== cap_d) stable_bad++;
        w1.a = cap_a; w1.d = cap_d; w1.len = we_len;
        wr_q.push_back(w1);
        we_len = 0;
      end
      prev_ce = ce1;
      if (we2 === 1'b0) begin
        if (we2_len == 0) begin
          cap2_a = a2;
          cap2_d = dq2;
        end
        we2_len++;
      end else if (we2_len != 0) begin
        w2.a = cap2_a; w2.d = cap2_d; w2.len = we2_len;
        wr2_q.push_back(w2);
        we2_len = 0;
      end
    end
  end

  task automatic drive_rx(input int which, input logic v);
    if (which == 0) rx1 = v;
    else            rx2 = v;
  endtask

  // Start + 8 data bits, then the stop bit held for 'tail' clocks.
  task automatic send_byte(input int which, input logic [7:0] b, input logic stop, input int tail);
    logic [8:0] frame;
    frame = {b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      drive_rx(which, frame[i]);
      repeat (CPB) @(negedge clk);
    end
    drive_rx(which, stop);
    repeat (tail) @(negedge clk);
    drive_rx(which, 1'b1);
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_write(input int which, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if ((which == 0 && wr_q.size() > 0) || (which != 0 && wr2_q.size() > 0)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #1;
    wr_q.delete();
    wr2_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vecs[3];
  wr_t         got;
  logic        ok;
  logic [15:0] words[$];
  logic        exp_err;
  int          nwords;

  initial begin
    rst_n = 1'b0;
    rx1   = 1'b1;
    rx2   = 1'b1;
    vecs[0] = '{lo: 8'h45, hi: 8'h81, addr: 18'd0, data: 16'h8145, cnt: 18'd1, done: 1'b0};
    vecs[1] = '{lo: 8'h60, hi: 8'h10, addr: 18'd1, data: 16'h1060, cnt: 18'd2, done: 1'b0};
    vecs[2] = '{lo: 8'h00, hi: 8'h00, addr: 18'd2, data: 16'h0000, cnt: 18'd3, done: 1'b1};

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("rst_we",    32'(we1),   32'd1);
    check("rst_ce",    32'(ce1),   32'd1);
    check("rst_oe",    32'(oe1),   32'd1);
    check("rst_lb_ub", 32'({lb1, ub1}), 32'd3);
    check("rst_a",     32'(a1),    32'd0);
    check("rst_dq",    32'(dq1),   32'd0);
    check("rst_dqoe",  32'(dqoe1), 32'd0);
    check("rst_done",  32'(done1), 32'd0);
    check("rst_err",   32'(err1),  32'd0);
    check("rst_count", 32'(cnt1),  32'd0);
    check("rst_no_write", 32'(wr_q.size()), 32'd0);

    for (int v = 0; v < 3; v++) begin
      send_byte(0, vecs[v].lo, 1'b1, CPB + 3);
      send_byte(0, vecs[v].hi, 1'b1, CPB + 3);
      wait_write(0, 200, ok);
      check($sformatf("vec%0d_write_seen", v), 32'(ok), 32'd1);
      if (ok) begin
        got = wr_q.pop_front();
        check($sformatf("vec%0d_addr", v), 32'(got.a), 32'(vecs[v].addr));
        check($sformatf("vec%0d_data", v), 32'(got.d), 32'(vecs[v].data));
        check($sformatf("vec%0d_we_len", v), 32'(got.len), 32'd3);
      end
      repeat (2) @(negedge clk);
      #1;
      check($sformatf("vec%0d_count", v), 32'(cnt1),  32'(vecs[v].cnt));
      check($sformatf("vec%0d_done", v),  32'(done1), 32'(vecs[v].done));
      check($sformatf("vec%0d_err", v),   32'(err1),  32'd0);
    end

    send_byte(0, 8'h55, 1'b1, CPB + 40);
    check("done_ignore_write", 32'(wr_q.size()), 32'd0);
    check("done_ignore_err",   32'(err1),  32'd0);
    check("done_sticky",       32'(done1), 32'd1);
    check("done_count",        32'(cnt1),  32'd3);
    check("done_bus_ce",       32'(ce1),   32'd1);

    do_reset();
    send_byte(0, 8'hA5, 1'b0, CPB + 4);
    check("frame_err_flag",   32'(err1), 32'd1);
    check("frame_err_nowrite", 32'(wr_q.size()), 32'd0);
    send_byte(0, 8'h34, 1'b1, CPB + 3);
    send_byte(0, 8'h92, 1'b1, CPB + 3);
    wait_write(0, 200, ok);
    check("frame_next_seen", 32'(ok), 32'd1);
    if (ok) begin
      got = wr_q.pop_front();
      check("frame_next_addr", 32'(got.a), 32'd0);
      check("frame_next_data", 32'(got.d), 32'h9234);
    end

    do_reset();
    send_byte(0, 8'hAB, 1'b1, CPB + 3);
    send_byte(0, 8'hCD, 1'b1, 0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (we1 === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("rstmid_pulse_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_we",    32'(we1),   32'd1);
    check("rstmid_ce",    32'(ce1),   32'd1);
    check("rstmid_dqoe",  32'(dqoe1), 32'd0);
    check("rstmid_a",     32'(a1),    32'd0);
    check("rstmid_count", 32'(cnt1),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    wr_q.delete();
    repeat (2 * CPB) @(negedge clk);

    do_reset();
    nwords  = 12 + int'($urandom_range(0, 7));
    exp_err = 1'b0;
    words.delete();
    for (int i = 0; i < nwords; i++) begin
      logic [15:0] wv;
      wv = 16'($urandom);
      if (i == nwords - 1)    wv[15:12] = 4'h0;
      else if (wv[15:12] == 4'h0) wv[15:12] = 4'($urandom_range(1, 15));
      words.push_back(wv);
    end
    for (int i = 0; i < nwords; i++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          send_byte(0, 8'($urandom), 1'b0, CPB + 2);
          exp_err = 1'b1;
        end
        send_byte(0, (k == 0) ? words[i][7:0] : words[i][15:8], 1'b1,
                  CPB + int'($urandom_range(0, 20)));
      end
    end
    repeat (30) @(negedge clk);
    #1;
    check("rand_write_count", 32'(wr_q.size()), 32'(nwords));
    for (int i = 0; i < nwords; i++) begin
      if (wr_q.size() == 0) break;
      got = wr_q.pop_front();
      check($sformatf("rand%0d_addr", i), 32'(got.a), 32'(i));
      check($sformatf("rand%0d_data", i), 32'(got.d), 32'(words[i]));
    end
    check("rand_count", 32'(cnt1),  32'(nwords));
    check("rand_done",  32'(done1), 32'd1);
    check("rand_err",   32'(err1),  32'(exp_err));

    do_reset();
    send_byte(1, 8'h11, 1'b1, CPB + 3);
    send_byte(1, 8'h22, 1'b1, CPB);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (we2 === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("ovr_pulse_seen", 32'(ok), 32'd1);
    send_byte(1, 8'h33, 1'b1, CPB + 2);
    check("ovr_first_no_err", 32'(err2), 32'd0);
    send_byte(1, 8'h44, 1'b1, CPB);
    check("ovr_err",         32'(err2), 32'd1);
    check("ovr_still_pulse", 32'(we2),  32'd0);
    wait_write(1, 1500, ok);
    check("ovr_w0_seen", 32'(ok), 32'd1);
    if (ok) begin
      got = wr2_q.pop_front();
      check("ovr_w0_addr", 32'(got.a), 32'd0);
      check("ovr_w0_data", 32'(got.d), 32'h2211);
      check("ovr_w0_len",  32'(got.len), 32'd1000);
    end
    send_byte(1, 8'h55, 1'b1, CPB);
    wait_write(1, 1500, ok);
    check("ovr_w1_seen", 32'(ok), 32'd1);
    if (ok) begin
      got = wr2_q.pop_front();
      check("ovr_w1_addr", 32'(got.a), 32'd1);
      check("ovr_w1_data", 32'(got.d), 32'h5533);
    end

    check("bus_oe_high",     32'(oe_bad),     32'd0);
    check("bus_idle_values", 32'(idle_bad),   32'd0);
    check("bus_write_cycle", 32'(stable_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
